// File: rtl/rgb_pwm_fader.sv
// rtl/rgb_pwm_fader.sv - RGB PWM generator with linear duty fading for SB_RGBA_DRV
//
// Purpose:
//   Accepts a target colour over a valid/ready handshake and ramps each
//   channel's duty toward it one LSB per fade step, or applies it at once.
//   Duties are latched only at PWM period boundaries, so the pins never see
//   a partially updated period.
//
// Ports:
//   clk          48 MHz system clock
//   rst          synchronous reset, active high
//   cmd_valid    target colour offered
//   cmd_ready    command accepted on this cycle's edge when cmd_valid is high
//   cmd_red      target red duty   (0 = off, 255 = 255/256 on)
//   cmd_green    target green duty
//   cmd_blue     target blue duty
//   cmd_instant  1: jump straight to the target, no ramp
//   busy         fade in progress
//   pwm_red      red PWM drive   (to SB_RGBA_DRV RGB0PWM)
//   pwm_green    green PWM drive (to SB_RGBA_DRV RGB1PWM)
//   pwm_blue     blue PWM drive  (to SB_RGBA_DRV RGB2PWM)
//
// Build option:
//   RGB_FADER_GAMMA_EN - when defined, the latched duty is (c*c + 255) >> 8
//   (gamma ~2); otherwise the latched duty equals the current duty.

module rgb_pwm_fader #(
  parameter int PRESCALE = 188,
  parameter int FADE_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_red,
  input  logic [7:0] cmd_green,
  input  logic [7:0] cmd_blue,
  input  logic       cmd_instant,
  output logic       busy,
  output logic       pwm_red,
  output logic       pwm_green,
  output logic       pwm_blue
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [FD_W-1:0] FD_LAST = FD_W'(FADE_DIV - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_FADING = 1'b1
  } state_t;

  // Channel index 0 = red, 1 = green, 2 = blue.
  state_t          state_q, state_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [FD_W-1:0] fade_cnt_q, fade_cnt_d;
  logic [2:0][7:0] cur_q, cur_d;
  logic [2:0][7:0] tgt_q, tgt_d;
  logic [2:0][7:0] lat_q, lat_d;
  logic [2:0]      pwm_q, pwm_d;

  logic            tick;
  logic            pend;
  logic            accept;
  logic [2:0][7:0] cmd_vec;
  logic [2:0][7:0] step_val;
  logic            step_done;

  // Maps a current duty to the value compared against pwm_cnt.
  function automatic logic [7:0] map_duty(input logic [7:0] c);
`ifdef RGB_FADER_GAMMA_EN
    logic [15:0] sq;
    // +255 rounds up so that 1 -> 1 and 255 -> 255; 255*255+255 fits 16 bits.
    sq = {8'd0, c} * {8'd0, c};
    return 8'((sq + 16'd255) >> 8);
`else
    return c;
`endif
  endfunction

  assign tick      = (presc_q == PS_LAST);
  assign pend      = tick && (pwm_cnt_q == 8'hFF);
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q == ST_FADING);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_vec   = {cmd_blue, cmd_green, cmd_red};

  assign pwm_red   = pwm_q[0];
  assign pwm_green = pwm_q[1];
  assign pwm_blue  = pwm_q[2];

  // One-LSB move toward the target; never overshoots, so no wrap at 0/255.
  always_comb begin
    step_val = cur_q;
    for (int i = 0; i < 3; i++) begin
      if (cur_q[i] < tgt_q[i]) begin
        step_val[i] = cur_q[i] + 8'd1;
      end else if (cur_q[i] > tgt_q[i]) begin
        step_val[i] = cur_q[i] - 8'd1;
      end
    end
    step_done = (step_val == tgt_q);
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    fade_cnt_d = fade_cnt_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    lat_d      = lat_q;

    // Latch from cur_q so a step on the same pend shows one period later.
    if (pend) begin
      for (int i = 0; i < 3; i++) begin
        lat_d[i] = map_duty(cur_q[i]);
      end
    end

    // Strict compare: duty 0 never produces a high count.
    for (int i = 0; i < 3; i++) begin
      pwm_d[i] = (pwm_cnt_q < lat_q[i]);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_instant) begin
            cur_d = cmd_vec;
          end else if (cmd_vec != cur_q) begin
            tgt_d      = cmd_vec;
            fade_cnt_d = '0;
            state_d    = ST_FADING;
          end
        end
      end
      ST_FADING: begin
        if (pend) begin
          if (fade_cnt_q == FD_LAST) begin
            fade_cnt_d = '0;
            cur_d      = step_val;
            if (step_done) begin
              state_d = ST_IDLE;
            end
          end else begin
            fade_cnt_d = fade_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      cur_q      <= '0;
      tgt_q      <= '0;
      lat_q      <= '0;
      pwm_q      <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      lat_q      <= lat_d;
      pwm_q      <= pwm_d;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb/tb_rgb_pwm_fader.sv - self-checking bench for rgb_pwm_fader
module tb_rgb_pwm_fader;

  logic       clk;
  logic       rst;
  logic       cmd_valid, cmd_valid4;
  logic       cmd_ready, cmd_ready4;
  logic [7:0] cmd_red, cmd_green, cmd_blue;
  logic       cmd_instant;
  logic       busy, busy4;
  logic       pwm_red, pwm_green, pwm_blue;
  logic       pwm_red4, pwm_green4, pwm_blue4;

  int total;
  int bad;
  int cyc;

  rgb_pwm_fader #(.PRESCALE(1), .FADE_DIV(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_red(cmd_red), .cmd_green(cmd_green), .cmd_blue(cmd_blue),
    .cmd_instant(cmd_instant), .busy(busy),
    .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue)
  );

  rgb_pwm_fader #(.PRESCALE(1), .FADE_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_red(cmd_red), .cmd_green(cmd_green), .cmd_blue(cmd_blue),
    .cmd_instant(cmd_instant), .busy(busy4),
    .pwm_red(pwm_red4), .pwm_green(pwm_green4), .pwm_blue(pwm_blue4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; period k occupies samples cyc = 256k+1 .. 256k+256.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int exp_duty(input int c);
`ifdef RGB_FADER_GAMMA_EN
    return (c * c + 255) / 256;
`else
    return c;
`endif
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_cmd(input bit sel, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input bit inst, output bit ok);
    @(negedge clk);
    cmd_red = r; cmd_green = g; cmd_blue = b; cmd_instant = inst;
    if (sel) cmd_valid4 = 1'b1; else cmd_valid = 1'b1;
    for (int n = 0; n < 3000 && !(sel ? cmd_ready4 : cmd_ready); n++) @(negedge clk);
    ok = sel ? cmd_ready4 : cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_valid4 = 1'b0;
  endtask

  // Counts high samples over one full PWM period, aligned to the period start.
  task automatic measure(input bit sel, input int skip, output int r, output int g,
                         output int b, output bit bhi);
    r = 0; g = 0; b = 0; bhi = 1'b0;
    repeat (skip) @(negedge clk);
    @(negedge clk);
    for (int n = 0; n < 300 && (cyc % 256) != 1; n++) @(negedge clk);
    for (int n = 0; n < 256; n++) begin
      if (n > 0) @(negedge clk);
      if (sel) begin
        r += int'(pwm_red4); g += int'(pwm_green4); b += int'(pwm_blue4);
        bhi = bhi | busy4;
      end else begin
        r += int'(pwm_red); g += int'(pwm_green); b += int'(pwm_blue);
        bhi = bhi | busy;
      end
    end
  endtask

  task automatic test_reset();
    int r, g, b; bit bhi;
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_valid4 = 1'b1;
    cmd_red = 8'd99; cmd_green = 8'd99; cmd_blue = 8'd99; cmd_instant = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({pwm_red, pwm_green, pwm_blue} !== 3'b000) begin bad++; $display("FAIL reset_pwm got=%b want=000", {pwm_red, pwm_green, pwm_blue}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cmd_ready); end
    total++; if (cmd_ready4 !== 1'b0) begin bad++; $display("FAIL reset_ready4 got=%b want=0", cmd_ready4); end
    rst = 1'b0; cmd_valid = 1'b0; cmd_valid4 = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", cmd_ready); end
    measure(1'b0, 2, r, g, b, bhi);
    total++; if (r !== 0 || g !== 0 || b !== 0) begin bad++; $display("FAIL reset_not_taken got=%0d/%0d/%0d want=0/0/0", r, g, b); end
  endtask

  task automatic test_instant();
    int r, g, b; bit bhi, ok;
    send_cmd(1'b0, 8'd64, 8'd0, 8'd255, 1'b1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL instant_accept got=%b want=1", ok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL instant_busy got=%b want=0", busy); end
    measure(1'b0, 2, r, g, b, bhi);
    total++; if (r !== exp_duty(64)) begin bad++; $display("FAIL instant_red got=%0d want=%0d", r, exp_duty(64)); end
    total++; if (g !== 0) begin bad++; $display("FAIL instant_green got=%0d want=0", g); end
    total++; if (b !== 255) begin bad++; $display("FAIL instant_blue got=%0d want=255", b); end
    total++; if (bhi !== 1'b0) begin bad++; $display("FAIL instant_busy_window got=%b want=0", bhi); end
  endtask

  task automatic test_fade();
    int r, g, b; bit bhi, ok;
    apply_reset();
    send_cmd(1'b0, 8'd0, 8'd10, 8'd0, 1'b0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fade_accept got=%b want=1", ok); end
    for (int j = 0; j <= 10; j++) begin
      measure(1'b0, (j == 0) ? 2 : 0, r, g, b, bhi);
      if (j == 0) begin
        // Held during the fade; must only be taken once busy drops.
        cmd_red = 8'd5; cmd_green = 8'd10; cmd_blue = 8'd0; cmd_instant = 1'b1;
        cmd_valid = 1'b1;
      end
      total++; if (g !== exp_duty(j)) begin bad++; $display("FAIL fade_green_%0d got=%0d want=%0d", j, g, exp_duty(j)); end
      total++; if (r !== ((j == 10) ? exp_duty(5) : 0)) begin bad++; $display("FAIL fade_held_red_%0d got=%0d want=%0d", j, r, (j == 10) ? exp_duty(5) : 0); end
      if (j == 0) begin
        total++; if (bhi !== 1'b1) begin bad++; $display("FAIL fade_busy_start got=%b want=1", bhi); end
      end
      if (j == 9) begin
        total++; if (bhi !== 1'b0) begin bad++; $display("FAIL fade_busy_end got=%b want=0", bhi); end
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_mixed();
    int r, g, b; bit bhi, ok;
    int exp_r[4] = '{200, 199, 198, 198};
    int exp_b[4] = '{3, 4, 5, 6};
    apply_reset();
    send_cmd(1'b0, 8'd200, 8'd0, 8'd3, 1'b1, ok);
    send_cmd(1'b0, 8'd198, 8'd0, 8'd6, 1'b0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mixed_accept got=%b want=1", ok); end
    for (int j = 0; j < 4; j++) begin
      measure(1'b0, (j == 0) ? 2 : 0, r, g, b, bhi);
      total++; if (r !== exp_duty(exp_r[j])) begin bad++; $display("FAIL mixed_red_%0d got=%0d want=%0d", j, r, exp_duty(exp_r[j])); end
      total++; if (b !== exp_duty(exp_b[j])) begin bad++; $display("FAIL mixed_blue_%0d got=%0d want=%0d", j, b, exp_duty(exp_b[j])); end
      if (j == 1) begin
        total++; if (bhi !== 1'b1) begin bad++; $display("FAIL mixed_busy_mid got=%b want=1", bhi); end
      end
      if (j == 3) begin
        total++; if (bhi !== 1'b0) begin bad++; $display("FAIL mixed_idle got=%b want=0", bhi); end
      end
    end
  endtask

  task automatic test_noop();
    int r, g, b; bit bhi, ok;
    send_cmd(1'b0, 8'd198, 8'd0, 8'd6, 1'b0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL noop_accept got=%b want=1", ok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL noop_busy got=%b want=0", busy); end
    measure(1'b0, 2, r, g, b, bhi);
    total++; if (bhi !== 1'b0) begin bad++; $display("FAIL noop_busy_window got=%b want=0", bhi); end
    total++; if (r !== exp_duty(198) || b !== exp_duty(6)) begin bad++; $display("FAIL noop_duty got=%0d/%0d want=%0d/%0d", r, b, exp_duty(198), exp_duty(6)); end
  endtask

  task automatic test_rate();
    int r, g, b, want; bit bhi, ok;
    apply_reset();
    send_cmd(1'b1, 8'd0, 8'd2, 8'd0, 1'b0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rate_accept got=%b want=1", ok); end
    for (int j = 0; j < 9; j++) begin
      measure(1'b1, (j == 0) ? 2 : 0, r, g, b, bhi);
      want = (j < 4) ? exp_duty(0) : ((j < 8) ? exp_duty(1) : exp_duty(2));
      total++; if (g !== want) begin bad++; $display("FAIL rate_green_%0d got=%0d want=%0d", j, g, want); end
      if (j == 6) begin
        total++; if (bhi !== 1'b1) begin bad++; $display("FAIL rate_busy_p7 got=%b want=1", bhi); end
      end
      if (j == 7) begin
        total++; if (bhi !== 1'b0) begin bad++; $display("FAIL rate_busy_p8 got=%b want=0", bhi); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int r, g, b; bit bhi, ok;
    apply_reset();
    send_cmd(1'b0, 8'd255, 8'd255, 8'd255, 1'b0, ok);
    repeat (600) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_fading got=%b want=1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({pwm_red, pwm_green, pwm_blue} !== 3'b000) begin bad++; $display("FAIL midrst_pwm got=%b want=000", {pwm_red, pwm_green, pwm_blue}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", cmd_ready); end
    send_cmd(1'b0, 8'd128, 8'd0, 8'd0, 1'b1, ok);
    measure(1'b0, 2, r, g, b, bhi);
    total++; if (r !== exp_duty(128) || g !== 0 || b !== 0) begin bad++; $display("FAIL midrst_duty got=%0d/%0d/%0d want=%0d/0/0", r, g, b, exp_duty(128)); end
  endtask

  task automatic test_gamma();
    int r, g, b; bit bhi, ok;
`ifdef RGB_FADER_GAMMA_EN
    int wr = 64;
`else
    int wr = 128;
`endif
    apply_reset();
    send_cmd(1'b0, 8'd128, 8'd255, 8'd1, 1'b1, ok);
    measure(1'b0, 2, r, g, b, bhi);
    total++; if (r !== wr) begin bad++; $display("FAIL gamma_128 got=%0d want=%0d", r, wr); end
    total++; if (g !== 255) begin bad++; $display("FAIL gamma_255 got=%0d want=255", g); end
    total++; if (b !== 1) begin bad++; $display("FAIL gamma_1 got=%0d want=1", b); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid4 = 1'b0;
    cmd_red = 8'd0; cmd_green = 8'd0; cmd_blue = 8'd0; cmd_instant = 1'b0;
    test_reset();
    test_instant();
    test_fade();
    test_mixed();
    test_noop();
    test_rate();
    test_mid_reset();
    test_gamma();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
